fetch_unit: RTL

- Instruction-fetch stage directly upstream of the 14-bit program ROM: owns the 11-bit program counter, drives the ROM address, and registers the returned word into the instruction register for the execute stage.
- Resolves control flow at fetch time: GOTO, CALL, RETURN and RETLW are handled here, with a circular hardware return stack.
- Accepts stall and skip requests from execute, and enters a halt state on SLEEP.

---
 rtl/fetch_unit.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//
// Instruction-fetch stage sitting in front of an asynchronous program ROM.
// It owns the program counter and presents it directly as the ROM address. The
// returned word is captured into the instruction register one cycle later.
// GOTO, CALL, RETURN and RETLW are resolved here against a circular return
// stack. SLEEP parks the stage in HALT until a wake pulse arrives.
//
// Ports
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   rom_addr          ROM address (always equals the program counter)
//   rom_data          ROM word for rom_addr, combinational
//   stall             execute not ready: every register holds
//   skip_req          drop the word fetched this cycle (no control-flow effect)
//   wake              leave HALT
//   ir, ir_valid      instruction register and its live flag
//   ir_pc             address ir was fetched from
//   halted            FSM is in HALT
//   stk_ovf, stk_unf  sticky return-stack overflow / underflow flags
//   dbg_state         FSM state (0 BOOT, 1 RUN, 2 HALT)
//   dbg_stk_count     return-stack occupancy (0..STACK_DEPTH)
//
// Handshake with execute: stall is a level that freezes the whole stage,
// including the FSM, and it takes priority over both skip_req and wake.
// skip_req is only honoured on a cycle where stall is low, so execute keeps it
// asserted until stall drops. wake is only honoured in HALT.
// -----------------------------------------------------------------------------
module fetch_unit #(
  parameter int              PC_W         = 11,
  parameter int              IW           = 14,
  parameter int              STACK_DEPTH  = 8,
  parameter logic [PC_W-1:0] RESET_VECTOR = '0
) (
  input  logic                           clk,
  input  logic                           rst_n,
  output logic [PC_W-1:0]                rom_addr,
  input  logic [IW-1:0]                  rom_data,
  input  logic                           stall,
  input  logic                           skip_req,
  input  logic                           wake,
  output logic [IW-1:0]                  ir,
  output logic                           ir_valid,
  output logic [PC_W-1:0]                ir_pc,
  output logic                           halted,
  output logic                           stk_ovf,
  output logic                           stk_unf,
  output logic [1:0]                     dbg_state,
  output logic [$clog2(STACK_DEPTH):0]   dbg_stk_count
);

  localparam int SP_W  = $clog2(STACK_DEPTH);
  localparam int CNT_W = SP_W + 1;

  localparam logic [IW-1:0]    OP_RETURN = IW'('h0008);
  localparam logic [IW-1:0]    OP_SLEEP  = IW'('h0063);
  localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(STACK_DEPTH);

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;

  logic [PC_W-1:0]     r_pc;
  logic [IW-1:0]       r_ir;
  logic                r_ir_valid;
  logic [PC_W-1:0]     r_ir_pc;
  logic [SP_W-1:0]     r_sp;
  logic [CNT_W-1:0]    r_count;
  logic [PC_W-1:0]     r_stack [STACK_DEPTH];
  logic                r_ovf;
  logic                r_unf;

  logic                w_is_goto;
  logic                w_is_call;
  logic                w_is_ret;
  logic                w_is_sleep;
  logic                w_fetch;
  logic                w_take;
  logic                w_push;
  logic                w_pop;
  logic [PC_W-1:0]     w_pc_inc;
  logic [PC_W-1:0]     w_pc_nxt;
  logic [SP_W-1:0]     w_sp_dec;
  logic [PC_W-1:0]     w_pop_data;

  // Opcode decode of the word currently on the ROM bus.
  assign w_is_goto  = (rom_data[13:11] == 3'b101);
  assign w_is_call  = (rom_data[13:11] == 3'b100);
  assign w_is_ret   = (rom_data == OP_RETURN) || (rom_data[13:10] == 4'b1101);
  assign w_is_sleep = (rom_data == OP_SLEEP);

  assign w_pc_inc   = r_pc + PC_W'(1);
  // Pop reads the entry below the pointer; the pointer wraps, so an empty
  // stack hands back whatever stale entry sits there.
  assign w_sp_dec   = r_sp - SP_W'(1);
  assign w_pop_data = r_stack[w_sp_dec];

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_BOOT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    if (!stall) begin
      case (r_state)
        S_BOOT:  w_state_nxt = S_RUN;
        // A skipped SLEEP is discarded like any other skipped word.
        S_RUN:   if (w_is_sleep && !skip_req) w_state_nxt = S_HALT;
        S_HALT:  if (wake) w_state_nxt = S_RUN;
        default: w_state_nxt = S_BOOT;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: output / datapath control
  // ---------------------------------------------------------------------------
  always_comb begin
    w_fetch  = (r_state == S_RUN) && !stall;
    w_take   = w_fetch && !skip_req;
    w_push   = w_take && w_is_call;
    w_pop    = w_take && w_is_ret;
    w_pc_nxt = r_pc;
    if (w_fetch) begin
      w_pc_nxt = w_pc_inc;
      if (w_take) begin
        if (w_is_goto || w_is_call) begin
          w_pc_nxt = rom_data[PC_W-1:0];
        end else if (w_is_ret) begin
          w_pc_nxt = w_pop_data;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Program counter and instruction register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc       <= RESET_VECTOR;
      r_ir       <= '0;
      r_ir_valid <= 1'b0;
      r_ir_pc    <= '0;
    end else begin
      r_pc <= w_pc_nxt;
      if (w_take) begin
        r_ir       <= rom_data;
        r_ir_pc    <= r_pc;
        r_ir_valid <= 1'b1;
      end else if (w_fetch) begin
        // Skipped word: the slot becomes a bubble.
        r_ir       <= '0;
        r_ir_valid <= 1'b0;
      end else if (!stall) begin
        // BOOT, HALT and the wake cycle never present a live instruction.
        r_ir_valid <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Circular return stack with saturating occupancy
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sp    <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
      for (int i = 0; i < STACK_DEPTH; i++) begin
        r_stack[i] <= '0;
      end
    end else if (w_push) begin
      // When full this overwrites the oldest entry, since sp has wrapped onto it.
      r_stack[r_sp] <= w_pc_inc;
      r_sp          <= r_sp + SP_W'(1);
      if (r_count == CNT_FULL) begin
        r_ovf <= 1'b1;
      end else begin
        r_count <= r_count + CNT_W'(1);
      end
    end else if (w_pop) begin
      r_sp <= w_sp_dec;
      if (r_count == '0) begin
        r_unf <= 1'b1;
      end else begin
        r_count <= r_count - CNT_W'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign rom_addr      = r_pc;
  assign ir            = r_ir;
  // The SLEEP word stays in ir while halted, but it is not presented as live.
  assign ir_valid      = r_ir_valid && (r_state == S_RUN);
  assign ir_pc         = r_ir_pc;
  assign halted        = (r_state == S_HALT);
  assign stk_ovf       = r_ovf;
  assign stk_unf       = r_unf;
  assign dbg_state     = r_state;
  assign dbg_stk_count = r_count;

endmodule
